enc_8_3_serial: RTL and testbench

ENC_8_3_SERIAL -- requirements
Module: enc_8_3_serial

---
 rtl/enc_pkg.sv | 12 +
 rtl/prio_enc_8_3.sv | 28 ++
 rtl/enc_8_3_serial.sv | 89 ++++++++
 tb/tb_enc_8_3_serial.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and widths for the serial 8-to-3 encoder.
package enc_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational priority encoder; LSB_FIRST picks lowest (1) or highest (0) set bit.
module prio_enc_8_3
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [IN_W-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // The last assignment in scan order wins, so scan away from the preferred end.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/enc_8_3_serial.sv
// Serialises a multi-hot 8-bit vector into one 3-bit index per set bit.
// Optional ENC_8_3_SERIAL_ZERO_EN: an all-zero vector emits one flagged beat on port zero.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// EMIT  | presenting indices from the pending register, out_valid high
module enc_8_3_serial
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] y,
`ifdef ENC_8_3_SERIAL_ZERO_EN
  output logic             zero,
`endif
  output logic             last
);

  state_t           state;
  logic [IN_W-1:0]  pending;
  logic [IDX_W-1:0] idx;
  logic             any;
  logic             one_left;
  logic             accept;
  logic             take;

  prio_enc_8_3 #(.LSB_FIRST(LSB_FIRST)) u_prio (
    .vec (pending),
    .idx (idx),
    .any (any)
  );

  assign out_valid = (state == EMIT);
  assign in_ready  = rst_n && (state == IDLE);
  assign y         = idx;
  assign one_left  = any && ((pending & (pending - IN_W'(1))) == '0);
  assign accept    = en && in_valid && in_ready;
  assign take      = en && out_valid && out_ready;

`ifdef ENC_8_3_SERIAL_ZERO_EN
  logic zero_q;

  assign last = out_valid && (one_left || zero_q);
  assign zero = out_valid && zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      pending <= d;
      state   <= EMIT;
      zero_q  <= (d == '0);
    end else if (take) begin
      pending <= pending & ~(IN_W'(1) << idx);
      if (last) begin
        state  <= IDLE;
        zero_q <= 1'b0;
      end
    end
  end
`else
  assign last = out_valid && one_left;

  // A zero vector is loaded but never leaves IDLE, so it is consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else if (accept) begin
      pending <= d;
      if (d != '0) state <= EMIT;
    end else if (take) begin
      pending <= pending & ~(IN_W'(1) << idx);
      if (last) state <= IDLE;
    end
  end
`endif

endmodule

// File: tb/tb_enc_8_3_serial.sv
// Self-checking bench for enc_8_3_serial; runs LSB-first and MSB-first instances in lockstep.
module tb_enc_8_3_serial;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] d;
  logic       out_ready;

  logic       in_ready, out_valid, last;
  logic [2:0] y;
  logic       in_ready_m, out_valid_m, last_m;
  logic [2:0] y_m;
  logic       zero, zero_m;

  int tests_run = 0;
  int tests_failed = 0;

  int exp_l[$];
  int exp_m[$];

  enc_8_3_serial #(.LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .out_valid(out_valid), .out_ready(out_ready), .y(y),
`ifdef ENC_8_3_SERIAL_ZERO_EN
    .zero(zero),
`endif
    .last(last)
  );

  enc_8_3_serial #(.LSB_FIRST(1'b0)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready_m),
    .d(d), .out_valid(out_valid_m), .out_ready(out_ready), .y(y_m),
`ifdef ENC_8_3_SERIAL_ZERO_EN
    .zero(zero_m),
`endif
    .last(last_m)
  );

`ifndef ENC_8_3_SERIAL_ZERO_EN
  assign zero   = 1'b0;
  assign zero_m = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference order: every set bit index, ascending for LSB-first, descending for MSB-first.
  task automatic build_expect(input logic [7:0] v);
    exp_l.delete();
    exp_m.delete();
    for (int i = 0; i < 8; i++) if (v[i]) exp_l.push_back(i);
    for (int i = 7; i >= 0; i--) if (v[i]) exp_m.push_back(i);
  endtask

  // mode 0: out_ready always 1; 1: toggles 1,0,...; 2: random
  task automatic run_vector(input logic [7:0] v, input int mode);
    int  k;
    int  n;
    int  cyc;
    bit  rdy;
    bit  zero_beat;
    build_expect(v);
    zero_beat = 1'b0;
    cyc = 0;
    while (!(in_ready && in_ready_m) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("in_ready_before_accept", {31'd0, in_ready && in_ready_m}, 32'd1);
    en = 1'b1;
    d = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    d = 8'($urandom);
`ifdef ENC_8_3_SERIAL_ZERO_EN
    if (v == 8'h00) begin
      exp_l.push_back(0);
      exp_m.push_back(0);
      zero_beat = 1'b1;
    end
`endif
    n = exp_l.size();
    k = 0;
    cyc = 0;
    while (k < n && cyc < 64) begin
      check("out_valid", {30'd0, out_valid, out_valid_m}, 32'd3);
      check("in_ready_busy", {30'd0, in_ready, in_ready_m}, 32'd0);
      check("y_lsb", {29'd0, y}, exp_l[k]);
      check("y_msb", {29'd0, y_m}, exp_m[k]);
      check("last", {30'd0, last, last_m}, (k == n - 1) ? 32'd3 : 32'd0);
      check("zero", {30'd0, zero, zero_m}, zero_beat ? 32'd3 : 32'd0);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      tick();
      if (rdy) k++;
      cyc++;
    end
    out_ready = 1'b0;
    check("beat_count", k, n);
    check("idle_out_valid", {30'd0, out_valid, out_valid_m}, 32'd0);
    check("idle_in_ready", {30'd0, in_ready, in_ready_m}, 32'd3);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    d = 8'h00;
    out_ready = 1'b0;

    #1;
    check("rst_in_ready", {30'd0, in_ready, in_ready_m}, 32'd0);
    check("rst_out_valid", {30'd0, out_valid, out_valid_m}, 32'd0);
    check("rst_y", {26'd0, y, y_m}, 32'd0);
    check("rst_last", {30'd0, last, last_m}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {30'd0, in_ready, in_ready_m}, 32'd3);

    run_vector(8'b0000_0001, 0);
    run_vector(8'b1010_0100, 0);
    run_vector(8'hFF, 1);

    // Reset after the first beat of 0x18 drops everything pending.
    d = 8'b0001_1000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rst_mid_first_y", {29'd0, y}, 32'd3);
    out_ready = 1'b1;
    tick();
    check("rst_mid_second_y", {29'd0, y}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {30'd0, out_valid, out_valid_m}, 32'd0);
    check("rst_mid_in_ready", {30'd0, in_ready, in_ready_m}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_emit", {30'd0, out_valid, out_valid_m}, 32'd0);
      check("rst_mid_ready", {30'd0, in_ready, in_ready_m}, 32'd3);
    end
    out_ready = 1'b0;

    // Zero vector handling.
    run_vector(8'h00, 0);

    // en=0 blocks the input handshake, then the output handshake.
    en = 1'b0;
    d = 8'h10;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en0_in_ready", {30'd0, in_ready, in_ready_m}, 32'd3);
      check("en0_no_accept", {30'd0, out_valid, out_valid_m}, 32'd0);
    end
    en = 1'b1;
    tick();
    in_valid = 1'b0;
    check("en1_out_valid", {30'd0, out_valid, out_valid_m}, 32'd3);
    check("en1_y", {26'd0, y, y_m}, {26'd0, 3'd4, 3'd4});
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("en0_hold_valid", {30'd0, out_valid, out_valid_m}, 32'd3);
      check("en0_hold_y", {29'd0, y}, 32'd4);
    end
    en = 1'b1;
    tick();
    out_ready = 1'b0;
    check("en1_done", {30'd0, out_valid, out_valid_m}, 32'd0);

    for (int t = 0; t < 25; t++) begin
      run_vector(8'($urandom), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
